// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants: mnemonic codes, opcodes and funct values.
// The decoder imports the same package, so the two sides cannot drift apart.
package instr_pkg;

  localparam logic [3:0] MN_NOP  = 4'd0;
  localparam logic [3:0] MN_ADDU = 4'd1;
  localparam logic [3:0] MN_SUBU = 4'd2;
  localparam logic [3:0] MN_OR   = 4'd3;
  localparam logic [3:0] MN_ORI  = 4'd4;
  localparam logic [3:0] MN_LUI  = 4'd5;
  localparam logic [3:0] MN_LW   = 4'd6;
  localparam logic [3:0] MN_SW   = 4'd7;
  localparam logic [3:0] MN_BEQ  = 4'd8;
  localparam logic [3:0] MN_J    = 4'd9;
  localparam logic [3:0] MN_JAL  = 4'd10;
  localparam logic [3:0] MN_JR   = 4'd11;
  localparam logic [3:0] MN_RLB  = 4'd12;

  localparam logic [3:0] LEGAL_MAX = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_RLB   = 6'b111111;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_JR   = 6'b001000;

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: symbolic mnemonic plus fields to a 32-bit MIPS word.
// Fields a format does not use are dropped, never merged into the word.
module mips_word_pack
  import instr_pkg::*;
(
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = 32'h0;
    legal_o = (mnem_i <= LEGAL_MAX);
    case (mnem_i)
      MN_ADDU: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_ADDU};
      MN_SUBU: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_SUBU};
      MN_OR:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, FN_OR};
      MN_JR:   word_o = {OP_RTYPE, rs_i, 15'b0, FN_JR};
      MN_ORI:  word_o = {OP_ORI, rs_i, rt_i, imm_i};
      MN_LUI:  word_o = {OP_LUI, 5'b0, rt_i, imm_i};
      MN_LW:   word_o = {OP_LW, rs_i, rt_i, imm_i};
      MN_SW:   word_o = {OP_SW, rs_i, rt_i, imm_i};
      MN_BEQ:  word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      MN_RLB:  word_o = {OP_RLB, rs_i, rt_i, imm_i};
      MN_J:    word_o = {OP_J, target_i};
      MN_JAL:  word_o = {OP_JAL, target_i};
      default: word_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts symbolic requests, emits packed words
// with sequential IM byte addresses through a one-entry output register.
module instr_encoder
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_mnem,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          err
);

  typedef enum logic {ST_LOAD, ST_FULL} state_e;

  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [31:0]   word;
  logic          legal;
  logic          accept;

  mips_word_pack u_pack (
    .mnem_i   (in_mnem),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .imm_i    (in_imm),
    .target_i (in_target),
    .word_o   (word),
    .legal_o  (legal)
  );

  assign full     = (state_q == ST_FULL);
  assign in_ready = !full && !restart && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    if (restart) begin
      // Session clear wins over drain and accept; a pending word is discarded.
      valid_d = 1'b0;
      count_d = '0;
      err_d   = 1'b0;
      state_d = ST_LOAD;
    end else begin
      if (valid_q && out_ready) valid_d = 1'b0;
      if (accept) begin
        if (legal) begin
          valid_d = 1'b1;
          data_d  = word;
          addr_d  = BASE_ADDR + (32'(count_q) << 2);
          count_d = count_q + 1'b1;
          if (count_d == CW'(DEPTH)) state_d = ST_FULL;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule
